// File: rtl/s298_net.sv
// Two-way signal-phase controller: synced enable/request/hold inputs drive a
// six-phase A/B sequence paced by a saturating timer (14 flops total).
module s298_net #(
  parameter int TIMER_W     = 8,
  parameter int A_GREEN_MIN = 15,
  parameter int YELLOW_END  = 3,
  parameter int ALLRED_END  = 1,
  parameter int B_GREEN_END = 31
) (
  input  logic clk,
  input  logic reset,
  input  logic g0,
  input  logic g1,
  input  logic g2,
  output logic o0,
  output logic o1,
  output logic o2,
  output logic o3,
  output logic o4,
  output logic o5
);

  localparam logic [2:0] AG  = 3'd0;
  localparam logic [2:0] AY  = 3'd1;
  localparam logic [2:0] ARB = 3'd2;
  localparam logic [2:0] BG  = 3'd3;
  localparam logic [2:0] BY  = 3'd4;
  localparam logic [2:0] RBA = 3'd5;

  localparam logic [TIMER_W-1:0] T_AGM = TIMER_W'(A_GREEN_MIN);
  localparam logic [TIMER_W-1:0] T_YE  = TIMER_W'(YELLOW_END);
  localparam logic [TIMER_W-1:0] T_ARE = TIMER_W'(ALLRED_END);
  localparam logic [TIMER_W-1:0] T_BGE = TIMER_W'(B_GREEN_END);
  localparam logic [TIMER_W-1:0] T_MAX = '1;
  localparam logic [TIMER_W-1:0] T_ONE = TIMER_W'(1);

  logic [2:0]         s;
  logic [2:0]         phase, phase_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic               leave;

  always_ff @(posedge clk) begin
    if (reset) begin
      s     <= 3'b000;
      phase <= AG;
      timer <= '0;
    end else begin
      s     <= {g2, g1, g0};
      phase <= phase_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    leave = 1'b0;
    case (phase)
      AG:      leave = (timer >= T_AGM) && s[1] && !s[2];
      AY:      leave = (timer == T_YE);
      ARB:     leave = (timer == T_ARE);
      BG:      leave = (timer >= T_BGE) && !s[2];
      BY:      leave = (timer == T_YE);
      RBA:     leave = (timer == T_ARE);
      default: leave = 1'b0;
    endcase
  end

  // Illegal codes recover to AG even while the enable is low.
  always_comb begin
    phase_nxt = phase;
    timer_nxt = timer;
    if (phase > RBA) begin
      phase_nxt = AG;
      timer_nxt = '0;
    end else if (s[0]) begin
      if (leave) begin
        phase_nxt = (phase == RBA) ? AG : phase + 3'd1;
        timer_nxt = '0;
      end else if (timer != T_MAX) begin
        timer_nxt = timer + T_ONE;
      end
    end
  end

  always_comb begin
    {o5, o4, o3, o2, o1, o0} = 6'b100100;
    case (phase)
      AG:      {o5, o4, o3, o2, o1, o0} = 6'b100001;
      AY:      {o5, o4, o3, o2, o1, o0} = 6'b100010;
      ARB:     {o5, o4, o3, o2, o1, o0} = 6'b100100;
      BG:      {o5, o4, o3, o2, o1, o0} = 6'b001100;
      BY:      {o5, o4, o3, o2, o1, o0} = 6'b010100;
      RBA:     {o5, o4, o3, o2, o1, o0} = 6'b100100;
      default: {o5, o4, o3, o2, o1, o0} = 6'b100100;
    endcase
  end

endmodule

// File: tb/tb_s298_net.sv
// Bench for s298_net: directed scenarios plus random traffic, checked each
// cycle against a phase-table reference model of the controller.
module tb_s298_net;

  logic clk = 1'b0;
  logic reset, g0, g1, g2;
  logic o0, o1, o2, o3, o4, o5;
  wire  [5:0] out = {o5, o4, o3, o2, o1, o0};

  int vectors = 0;
  int miscompares = 0;

  s298_net dut (
    .clk(clk), .reset(reset), .g0(g0), .g1(g1), .g2(g2),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5)
  );

  always #5 clk = ~clk;

  // Reference model: phase index 0..5 (AG,AY,ARB,BG,BY,RBA), timer as int.
  bit m_en, m_req, m_hold;
  int m_ph, m_tm;

  function automatic logic [5:0] lights(input int p);
    case (p)
      0: return 6'b100001;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b001100;
      4: return 6'b010100;
      5: return 6'b100100;
      default: return 6'b100100;
    endcase
  endfunction

  function automatic bit may_leave(input int p, input int t, input bit req, input bit hold);
    case (p)
      0: return (t >= 15) && req && !hold;
      1: return t == 3;
      2: return t == 1;
      3: return (t >= 31) && !hold;
      4: return t == 3;
      5: return t == 1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit a, input bit b, input bit c);
    if (r) begin
      m_en = 0; m_req = 0; m_hold = 0; m_ph = 0; m_tm = 0;
      return;
    end
    if (m_ph > 5) begin
      m_ph = 0; m_tm = 0;
    end else if (m_en) begin
      if (may_leave(m_ph, m_tm, m_req, m_hold)) begin
        m_ph = (m_ph + 1) % 6; m_tm = 0;
      end else if (m_tm < 255) begin
        m_tm = m_tm + 1;
      end
    end
    m_en = a; m_req = b; m_hold = c;
  endtask

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_out"}, {2'b00, out}, {2'b00, lights(m_ph)});
    chk({tag, "_tmr"}, dut.timer, 8'(m_tm));
  endtask

  task automatic step(input bit r, input bit a, input bit b, input bit c);
    reset = r; g0 = a; g1 = b; g2 = c;
    @(posedge clk);
    model_edge(r, a, b, c);
    @(negedge clk);
    check_model("cyc");
  endtask

  task automatic do_reset();
    step(1, 1'($urandom), 1'($urandom), 1'($urandom));
    step(1, 1'($urandom), 1'($urandom), 1'($urandom));
    chk("rst_out", {2'b00, out}, 8'b00100001);
    chk("rst_tmr", dut.timer, 8'd0);
  endtask

  task automatic bound_fail(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s observed=timeout expected=reached", tag);
  endtask

  initial begin
    int n;
    int frozen;
    reset = 1'b1; g0 = 1'b0; g1 = 1'b0; g2 = 1'b0;
    @(negedge clk);

    // Full cycle with request held: 60-edge period.
    do_reset();
    for (int e = 1; e <= 61; e++) begin
      step(0, 1, 1, 0);
      if (e == 16) chk("ag16", {2'b00, out}, 8'b00100001);
      if (e == 17) chk("ay17", {2'b00, out}, 8'b00100010);
      if (e == 21) chk("arb21", {2'b00, out}, 8'b00100100);
      if (e == 23) chk("bg23", {2'b00, out}, 8'b00001100);
      if (e == 55) chk("by55", {2'b00, out}, 8'b00010100);
      if (e == 59) chk("rba59", {2'b00, out}, 8'b00100100);
      if (e == 61) chk("ag61", {2'b00, out}, 8'b00100001);
    end

    // No request: A-green holds, timer saturates at 255.
    do_reset();
    for (int e = 0; e < 300; e++) step(0, 1, 0, 0);
    chk("sat_tmr", dut.timer, 8'd255);
    chk("sat_out", {2'b00, out}, 8'b00100001);
    step(0, 1, 1, 0);
    chk("req_lat1", {2'b00, out}, 8'b00100001);
    step(0, 1, 1, 0);
    chk("req_lat2", {2'b00, out}, 8'b00100010);

    // Hold in B-green from timer 20 for 100 cycles.
    do_reset();
    n = 0;
    while (!(m_ph == 3 && m_tm == 20) && n < 200) begin step(0, 1, 1, 0); n++; end
    if (n >= 200) bound_fail("reach_bg20");
    for (int e = 0; e < 100; e++) step(0, 1, 1, 1);
    chk("hold_bg", {2'b00, out}, 8'b00001100);
    step(0, 1, 1, 0);
    chk("unhold1", {2'b00, out}, 8'b00001100);
    step(0, 1, 1, 0);
    chk("unhold2", {2'b00, out}, 8'b00010100);

    // Enable dropped mid A-yellow: everything freezes.
    do_reset();
    n = 0;
    while (!(m_ph == 1 && m_tm == 1) && n < 200) begin step(0, 1, 1, 0); n++; end
    if (n >= 200) bound_fail("reach_ay1");
    step(0, 0, 1, 0);
    frozen = m_tm;
    for (int e = 0; e < 10; e++) step(0, 0, 1, 0);
    chk("frz_tmr", dut.timer, 8'(frozen));
    chk("frz_out", {2'b00, out}, 8'b00100010);
    for (int e = 0; e < 4; e++) step(0, 1, 1, 0);

    // Illegal code deposit recovers to AG even with enable low.
    step(0, 0, 0, 0);
    dut.phase <= 3'd7;
    m_ph = 7;
    #1;
    chk("ill_out", {2'b00, out}, 8'b00100100);
    @(negedge clk);
    step(0, 0, 0, 0);
    chk("ill_rec_out", {2'b00, out}, 8'b00100001);
    chk("ill_rec_tmr", dut.timer, 8'd0);

    // Random traffic with occasional resets.
    for (int e = 0; e < 3000; e++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/s298_net.md
Name: s298_net

Overview:
- Small synchronous two-way signal-phase controller: 3 single-bit control inputs, 6 single-bit phase outputs, exactly 14 state flip-flops.
- Flops: 3 input-sync, 3 phase, 8 timer.
- Sits as a flat gate/RTL netlist target for fault simulation and fault-collapsing flows, so the flop count and the port list are fixed.

Parameters:
- TIMER_W, 8: timer width; saturates at 2^TIMER_W-1.
- A_GREEN_MIN, 15: timer value at or above which A-green may end on request.
- YELLOW_END, 3: timer value ending a yellow phase.
- ALLRED_END, 1: timer value ending an all-red phase.
- B_GREEN_END, 31: timer value at or above which B-green ends.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- g0  input  1  enable; timer advances and phases may change only when the synced copy is 1.
- g1  input  1  request; side request to leave A-green.
- g2  input  1  hold; blocks leaving either green phase.
- o0  output  1  A green.
- o1  output  1  A yellow.
- o2  output  1  A red.
- o3  output  1  B green.
- o4  output  1  B yellow.
- o5  output  1  B red.

Behaviour:
- Reset is synchronous and active-high: at a clk edge with reset=1, sync regs s[2:0]=0, phase=AG(0), timer=0. Reset mid-phase behaves identically.
- Input sync: every non-reset edge, s0<=g0, s1<=g1, s2<=g2. The FSM uses only s*, giving 1 cycle of input latency.
- Phases (3-bit code): AG=0, AY=1, ARB=2, BG=3, BY=4, RBA=5. Codes 6 and 7 are illegal.
- Transitions are evaluated only when s0=1. When s0=0, phase and timer hold.
  - AG -> AY when timer>=A_GREEN_MIN && s1 && !s2.
  - AY -> ARB when timer==YELLOW_END.
  - ARB -> BG when timer==ALLRED_END.
  - BG -> BY when timer>=B_GREEN_END && !s2.
  - BY -> RBA when timer==YELLOW_END.
  - RBA -> AG when timer==ALLRED_END.
- Timer update:
  - On any transition, timer<=0.
  - Otherwise, if s0=1, timer<=timer+1, saturating at 255 (never wraps).
- Illegal phase 6 or 7: next edge forces AG with timer=0, regardless of s0.
- Outputs are combinational decodes of the phase register only:
  - o0 = (phase==AG), o1 = (phase==AY), o2 = phase in {ARB,BG,BY,RBA}.
  - o3 = (phase==BG), o4 = (phase==BY), o5 = phase in {AG,AY,ARB,RBA}.
  - Illegal codes: o2=o5=1, all others 0.
- Invariant in legal states: exactly one of o0/o1/o2 is set and exactly one of o3/o4/o5 is set; o0 and o3 are never both 1.
- Priority: reset > illegal-state recovery > enable-gated transition > timer increment.
- Hold with timer saturated: phase stays; timer remains 255; the transition occurs on the first enabled edge after s2 drops.

Test Plan:
- Reset with any inputs for 2 cycles -> {o5..o0}=6'b100001, timer=0.
- After reset, g0=g1=1, g2=0 held constant (edge 1 = first edge after reset release):
  - AY (6'b100010) entered at edge 17.
  - ARB (6'b100100) at edge 21.
  - BG (6'b001100) at edge 23.
  - BY (6'b010100) at edge 55.
  - RBA (6'b100100) at edge 59.
  - AG again at edge 61, giving a 60-cycle period.
- Same as above but g1=0 -> stays AG indefinitely; timer saturates at 255 without wrapping; raising g1 moves to AY 2 edges later.
- In BG, assert g2 from the BG timer value 20 onward for 100 cycles -> BG held; dropping g2 gives BY 2 edges later.
- Toggle g0=0 for 10 cycles mid-AY -> outputs and timer frozen; resumes the count on re-enable.
- Force phase=7 via hierarchical deposit -> o2=o5=1 for one cycle, then AG with timer 0.
